// File: rtl/svc_rv_idex.sv
// Decode-to-execute pipeline register for the RV32I core: operand forwarding,
// ALU operand select, load-use hazard detection and valid/ready handshake.
module svc_rv_idex #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,

    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rd,
    input  logic            id_reg_write,
    input  logic            id_is_load,
    input  logic [2:0]      id_alu_op,
    input  logic [1:0]      id_a_sel,
    input  logic            id_b_sel,

    input  logic [XLEN-1:0] ex_result,
    input  logic            mem_valid,
    input  logic            mem_reg_write,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_valid,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,

    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_alu_a,
    output logic [XLEN-1:0] ex_alu_b,
    output logic [2:0]      ex_alu_op,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_is_load
);

    logic            advance;
    logic            hazard;
    logic            xfer;
    logic            ex_fwd_ok;
    logic            ex_load_ok;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic [XLEN-1:0] alu_a_next;
    logic [XLEN-1:0] alu_b_next;

    assign ex_fwd_ok  = ex_valid && ex_reg_write && !ex_is_load;
    assign ex_load_ok = ex_valid && ex_reg_write && ex_is_load && (ex_rd != 5'd0);

    assign hazard   = ex_load_ok && ((id_rs1_used && (id_rs1 == ex_rd)) ||
                                     (id_rs2_used && (id_rs2 == ex_rd)));
    assign advance  = !ex_valid || ex_ready;
    assign id_ready = advance && !hazard && !flush;
    assign xfer     = id_valid && id_ready;

    // Priority EX > MEM > WB > regfile; x0 always takes the regfile value.
    function automatic logic [XLEN-1:0] forward(input logic [4:0]      rs,
                                                input logic [XLEN-1:0] rf,
                                                input logic            ex_ok,
                                                input logic [4:0]      erd,
                                                input logic [XLEN-1:0] eres,
                                                input logic            m_ok,
                                                input logic [4:0]      mrd,
                                                input logic [XLEN-1:0] mdat,
                                                input logic            w_ok,
                                                input logic [4:0]      wrd,
                                                input logic [XLEN-1:0] wdat);
        logic [XLEN-1:0] r;
        r = rf;
        if (rs != 5'd0) begin
            if (ex_ok && (erd == rs))
                r = eres;
            else if (m_ok && (mrd == rs))
                r = mdat;
            else if (w_ok && (wrd == rs))
                r = wdat;
        end
        return r;
    endfunction

    always_comb begin
        rs1_fwd = forward(id_rs1, id_rs1_data, ex_fwd_ok, ex_rd, ex_result,
                          mem_valid && mem_reg_write, mem_rd, mem_data,
                          wb_valid && wb_reg_write, wb_rd, wb_data);
        rs2_fwd = forward(id_rs2, id_rs2_data, ex_fwd_ok, ex_rd, ex_result,
                          mem_valid && mem_reg_write, mem_rd, mem_data,
                          wb_valid && wb_reg_write, wb_rd, wb_data);
    end

    always_comb begin
        alu_a_next = '0;
        case (id_a_sel)
            2'd0:    alu_a_next = rs1_fwd;
            2'd1:    alu_a_next = id_pc;
            default: alu_a_next = '0;
        endcase
        alu_b_next = id_b_sel ? id_imm : rs2_fwd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_alu_a     <= '0;
            ex_alu_b     <= '0;
            ex_alu_op    <= '0;
            ex_rs2_data  <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_is_load   <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (xfer) begin
            ex_valid     <= 1'b1;
            ex_pc        <= id_pc;
            ex_alu_a     <= alu_a_next;
            ex_alu_b     <= alu_b_next;
            ex_alu_op    <= id_alu_op;
            ex_rs2_data  <= rs2_fwd;
            ex_rd        <= id_rd;
            ex_reg_write <= id_reg_write;
            ex_is_load   <= id_is_load;
        end else if (advance) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_svc_rv_idex.sv
// Directed bench for svc_rv_idex: forwarding, load-use bubble, stall, flush, reset.
module tb_svc_rv_idex;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rs1_used, id_rs2_used, id_reg_write, id_is_load, id_b_sel;
    logic [2:0]  id_alu_op;
    logic [1:0]  id_a_sel;
    logic [31:0] ex_result, mem_data, wb_data;
    logic        mem_valid, mem_reg_write, wb_valid, wb_reg_write;
    logic [4:0]  mem_rd, wb_rd;
    logic        ex_valid, ex_ready, ex_reg_write, ex_is_load;
    logic [31:0] ex_pc, ex_alu_a, ex_alu_b, ex_rs2_data;
    logic [2:0]  ex_alu_op;
    logic [4:0]  ex_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Adder stands in for the ALU so EX forwarding sees a real result.
    assign ex_result = ex_alu_a + ex_alu_b;

    svc_rv_idex #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .id_alu_op(id_alu_op),
        .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
        .ex_result(ex_result),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
        .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
        .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_alu_op(ex_alu_op),
        .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2, input logic [31:0] imm,
                         input logic [4:0] rd, input logic rw, input logic ld,
                         input logic [2:0] op, input logic [1:0] asel, input logic bsel);
        id_valid = 1'b1; id_pc = pc;
        id_rs1 = rs1; id_rs1_used = 1'b1; id_rs1_data = d1;
        id_rs2 = rs2; id_rs2_used = !bsel; id_rs2_data = d2;
        id_imm = imm; id_rd = rd; id_reg_write = rw; id_is_load = ld;
        id_alu_op = op; id_a_sel = asel; id_b_sel = bsel;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        mem_valid = 1'b0; mem_reg_write = 1'b0; mem_rd = '0; mem_data = '0;
        wb_valid = 1'b0; wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
        instr(32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
        id_valid = 1'b0;
        cyc(); cyc();
        check("rst_valid", {31'b0, ex_valid}, 32'h0);
        check("rst_alu_a", ex_alu_a, 32'h0);
        check("rst_rw", {31'b0, ex_reg_write}, 32'h0);
        rst = 1'b0;
        #1;
        check("rst_id_ready", {31'b0, id_ready}, 32'h1);

        // addi x1,x0,5 then add x2,x1,x1 (stale regfile data 0x55)
        instr(32'h100, 5'd0, 32'h0, 5'd0, 32'h0, 32'd5, 5'd1, 1'b1, 1'b0, 3'd0, 2'd0, 1'b1);
        cyc();
        check("addi_valid", {31'b0, ex_valid}, 32'h1);
        check("addi_b", ex_alu_b, 32'd5);
        check("addi_pc", ex_pc, 32'h100);
        instr(32'h104, 5'd1, 32'h55, 5'd1, 32'h55, 32'h0, 5'd2, 1'b1, 1'b0, 3'd2, 2'd0, 1'b0);
        check("add_no_bubble", {31'b0, id_ready}, 32'h1);
        cyc();
        check("add_fwd_a", ex_alu_a, 32'd5);
        check("add_fwd_b", ex_alu_b, 32'd5);
        check("add_rs2", ex_rs2_data, 32'd5);
        check("add_op", {29'b0, ex_alu_op}, 32'd2);

        // lw x3 then add x4,x3,x0: one bubble, then MEM forwarding
        instr(32'h108, 5'd0, 32'h0, 5'd0, 32'h0, 32'h40, 5'd3, 1'b1, 1'b1, 3'd0, 2'd0, 1'b1);
        cyc();
        check("lw_load", {31'b0, ex_is_load}, 32'h1);
        instr(32'h10C, 5'd3, 32'h1234, 5'd0, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0);
        check("hazard_id_ready", {31'b0, id_ready}, 32'h0);
        cyc();
        check("bubble_valid", {31'b0, ex_valid}, 32'h0);
        mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd3; mem_data = 32'hDEADBEEF;
        #1;
        check("post_bubble_ready", {31'b0, id_ready}, 32'h1);
        cyc();
        check("lu_valid", {31'b0, ex_valid}, 32'h1);
        check("lu_mem_fwd", ex_alu_a, 32'hDEADBEEF);
        check("lu_b", ex_alu_b, 32'h0);

        // priority: EX x5=7, MEM x5=9, WB x5=11
        instr(32'h110, 5'd0, 32'h0, 5'd0, 32'h0, 32'd7, 5'd5, 1'b1, 1'b0, 3'd0, 2'd0, 1'b1);
        cyc();
        mem_rd = 5'd5; mem_data = 32'd9;
        wb_valid = 1'b1; wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'd11;
        instr(32'h114, 5'd5, 32'h42, 5'd0, 32'h0, 32'h0, 5'd6, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1);
        cyc();
        check("prio_ex", ex_alu_a, 32'd7);
        cyc();
        check("prio_mem", ex_alu_a, 32'd9);
        mem_valid = 1'b0;
        cyc();
        check("prio_wb", ex_alu_a, 32'd11);
        wb_valid = 1'b0;
        cyc();
        check("prio_rf", ex_alu_a, 32'h42);

        // x0: every stage claims rd=0 with all-ones data
        instr(32'h118, 5'd0, 32'h0, 5'd0, 32'h0, 32'hFFFFFFFF, 5'd0, 1'b1, 1'b0, 3'd0, 2'd0, 1'b1);
        cyc();
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFFFFFF;
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
        instr(32'h11C, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0);
        cyc();
        check("x0_a", ex_alu_a, 32'h0);
        check("x0_b", ex_alu_b, 32'h0);
        mem_valid = 1'b0; wb_valid = 1'b0;

        // downstream stall for three cycles
        ex_ready = 1'b0;
        instr(32'h200, 5'd0, 32'h0, 5'd0, 32'h0, 32'd3, 5'd8, 1'b1, 1'b0, 3'd1, 2'd1, 1'b1);
        for (int unsigned i = 0; i < 3; i++) begin
            check("stall_id_ready", {31'b0, id_ready}, 32'h0);
            cyc();
            check("stall_rd", {27'b0, ex_rd}, 32'd7);
            check("stall_pc", ex_pc, 32'h11C);
            check("stall_valid", {31'b0, ex_valid}, 32'h1);
        end
        ex_ready = 1'b1;
        #1;
        check("release_ready", {31'b0, id_ready}, 32'h1);
        cyc();
        check("release_rd", {27'b0, ex_rd}, 32'd8);
        check("release_a_pc", ex_alu_a, 32'h200);
        check("release_b", ex_alu_b, 32'd3);

        // flush with id_valid: incoming instruction is dropped
        instr(32'h300, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 3'd0, 2'd0, 1'b1);
        flush = 1'b1;
        #1;
        check("flush_id_ready", {31'b0, id_ready}, 32'h0);
        cyc();
        check("flush_valid", {31'b0, ex_valid}, 32'h0);
        check("flush_no_capture", {27'b0, ex_rd}, 32'd8);
        flush = 1'b0;
        cyc();
        check("after_flush_rd", {27'b0, ex_rd}, 32'd9);
        check("after_flush_valid", {31'b0, ex_valid}, 32'h1);

        // flush overrides a downstream stall
        ex_ready = 1'b0; flush = 1'b1;
        cyc();
        check("flush_stall_valid", {31'b0, ex_valid}, 32'h0);
        flush = 1'b0; ex_ready = 1'b1;
        instr(32'h304, 5'd0, 32'h0, 5'd0, 32'h0, 32'd1, 5'd10, 1'b1, 1'b0, 3'd0, 2'd1, 1'b1);
        cyc();
        check("pre_rst_valid", {31'b0, ex_valid}, 32'h1);

        // reset mid-stall
        ex_ready = 1'b0; rst = 1'b1;
        cyc();
        check("mid_rst_valid", {31'b0, ex_valid}, 32'h0);
        check("mid_rst_a", ex_alu_a, 32'h0);
        check("mid_rst_pc", ex_pc, 32'h0);
        check("mid_rst_rd", {27'b0, ex_rd}, 32'h0);
        rst = 1'b0; id_valid = 1'b0;
        #1;
        check("post_rst_ready", {31'b0, id_ready}, 32'h1);
        cyc();
        check("idle_valid", {31'b0, ex_valid}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/svc_rv_idex.md
# svc_rv_idex

Decode-to-execute pipeline register for the RV32I core. It captures a decoded instruction and resolves operand forwarding from the EX, MEM and WB stages. It selects ALU operand sources and presents registered `a`, `b` and `alu_op` directly to the combinational ALU. It also detects load-use hazards, stalls decode, and honours downstream backpressure and pipeline flush through a valid/ready handshake.

## Interface
Parameters:
- `XLEN`, 32, datapath width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: kill the held instruction and refuse new input this cycle.
- `id_valid` in 1: decode offers an instruction.
- `id_ready` out 1: this block accepts it this cycle.
- `id_pc` in XLEN: instruction PC.
- `id_rs1`, `id_rs2` in 5 each: source register indices.
- `id_rs1_used`, `id_rs2_used` in 1 each: the source is actually read.
- `id_rs1_data`, `id_rs2_data` in XLEN each: regfile read data, refreshed every cycle while `id_valid` is held.
- `id_imm` in XLEN: sign-extended immediate.
- `id_rd` in 5: destination register.
- `id_reg_write` in 1: writes `rd`.
- `id_is_load` in 1: load instruction.
- `id_alu_op` in 3: ALU operation code.
- `id_a_sel` in 2: operand A source. 0 = rs1, 1 = pc, 2 = zero, 3 = reserved (zero).
- `id_b_sel` in 1: operand B source. 0 = rs2, 1 = imm.
- `ex_result` in XLEN: current ALU result for the instruction held here.
- `mem_valid`, `mem_reg_write` in 1 each: MEM-stage producer status.
- `mem_rd` in 5, `mem_data` in XLEN: MEM-stage producer destination and data.
- `wb_valid`, `wb_reg_write` in 1 each: WB-stage producer status.
- `wb_rd` in 5, `wb_data` in XLEN: WB-stage producer destination and data.
- `ex_valid` out 1: held instruction is valid.
- `ex_ready` in 1: EX consumes the held instruction.
- `ex_pc` out XLEN: held instruction PC.
- `ex_alu_a`, `ex_alu_b` out XLEN each: ALU operands.
- `ex_alu_op` out 3: ALU operation code.
- `ex_rs2_data` out XLEN: forwarded rs2, used as store data.
- `ex_rd` out 5: held destination register.
- `ex_reg_write` out 1: held instruction writes `rd`.
- `ex_is_load` out 1: held instruction is a load.

## Operation
**Handshake.**
- `advance = !ex_valid || ex_ready`.
- `id_ready = advance && !hazard && !flush`.
- `xfer = id_valid && id_ready`.

**Load-use hazard.** `hazard` is asserted when all of the following hold:
- `ex_valid && ex_reg_write && ex_is_load && ex_rd != 0`.
- At least one used source matches: `(id_rs1_used && id_rs1 == ex_rd)` or `(id_rs2_used && id_rs2 == ex_rd)`.

**Forwarding.** Applied per source at capture time, highest priority first:
1. EX: `ex_valid && ex_reg_write && !ex_is_load && ex_rd == rs` selects `ex_result`.
2. MEM: `mem_valid && mem_reg_write && mem_rd == rs` selects `mem_data`.
3. WB: `wb_valid && wb_reg_write && wb_rd == rs` selects `wb_data`.
4. Otherwise `id_rsN_data`.

Index 0 never forwards; it always yields `id_rsN_data`, which is 0.

**Operand select.**
- A: rs1 forwarded, `id_pc`, or 0, per `id_a_sel`.
- B: rs2 forwarded or `id_imm`, per `id_b_sel`.
- `ex_rs2_data` is always rs2 forwarded.

**Register update, per cycle, in priority order:**
- `rst`: `ex_valid` = 0. All data outputs = 0, including `ex_reg_write` and `ex_is_load`.
- `flush`: `ex_valid` ← 0. Data outputs are don't-care but held.
- `xfer`: all `ex_*` ← captured/forwarded values, and `ex_valid` ← 1.
- `advance && !xfer`: `ex_valid` ← 0 (bubble). Data fields are held.
- Otherwise (stall): all outputs held.

## Timing
- Latency: one cycle from `xfer` to `ex_valid`. Full throughput when `ex_ready` = 1 and no hazard.
- Load-use hazard costs exactly one bubble cycle. On the following cycle the load has moved to MEM and MEM forwarding supplies `mem_data`.
- While `ex_valid && !ex_ready`, every `ex_*` output is stable and `id_ready` = 0.
- `id_ready` is combinational from `ex_valid`, `ex_ready`, `flush`, the `ex_*` registers and the `id_rs*` fields. It must not depend on `id_valid`.
- The `ex_result` → `ex_alu_a`/`ex_alu_b` path is a single-cycle combinational loop through the ALU. It is broken only by this block's registers.
- `flush` together with `id_valid`: no transfer; `ex_valid` = 0 next cycle.
- `flush` during a downstream stall: `ex_valid` is still cleared; flush overrides the stall.
- Reset asserted mid-stall: `ex_valid` = 0 next cycle, and `id_ready` follows the rule above once `rst` deasserts.

## Test plan
- Back-to-back `addi x1,x0,5` then `add x2,x1,x1`. The second instruction captures `ex_alu_a` = `ex_alu_b` = 5 via EX forwarding, with no bubble.
- `lw x3` followed by `add x4,x3,x0`:
  - `id_ready` = 0 for one cycle and `ex_valid` = 0 for one cycle.
  - `add` then captures `ex_alu_a` = `mem_data` (0xDEADBEEF).
- Priority check: EX writes x5 = 7, MEM writes x5 = 9 and WB writes x5 = 11. Required: `ex_alu_a` = 7. With EX removed: 9. With MEM also removed: 11.
- Register x0: all stages drive `rd` = 0 with data 0xFFFFFFFF. Required: operand captured as 0.
- Hold `ex_ready` = 0 for 3 cycles with `id_valid` = 1:
  - Outputs are constant and `id_ready` = 0.
  - On release, the next instruction is captured in the same cycle the held one is consumed.
- Assert `flush` for one cycle with `ex_valid` = 1 and `id_valid` = 1. Required: `ex_valid` = 0 next cycle, the incoming instruction is not captured, and `rst` mid-stream clears `ex_valid` and zeroes the data outputs.
